// File: rtl/pipeline_stall_controller_pkg.sv
// -----------------------------------------------------------------------------
// pipeline_stall_controller_pkg
// Shared definitions for the IITB-RISC pipeline control slice: controller FSM
// state encoding, architectural register count and the bubble instruction.
// No ports (package).
// -----------------------------------------------------------------------------
package pipeline_stall_controller_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        MC_SEQ   = 2'd2
    } state_t;

    localparam int NUM_REGS  = 8;
    localparam int REG_IDX_W = $clog2(NUM_REGS);

    // Width of the load-use bubble counter; holds LOAD_USE_BUBBLES-1 (max 2).
    localparam int BUB_CNT_W = 2;

    // Instruction word the RR/EX register loads when rr_ex_bubble is asserted.
    localparam logic [15:0] NOP_INSTR = 16'hB000;

endpackage : pipeline_stall_controller_pkg

// File: rtl/pipeline_stall_controller_if.sv
// -----------------------------------------------------------------------------
// pipeline_stall_controller_if
// Bundles the hazard/redirect/LM-SM requests into the stall controller and the
// pipeline-register enables, bubble and flush controls coming back out.
//   master : request producer / control consumer (pipeline datapath side)
//   slave  : the stall controller
// Signals:
//   should_stall, flush_ex, mc_start, mc_mask[MASK_W]   requests
//   pc_en, if_id_en, id_rr_en, rr_ex_en                 register enables
//   rr_ex_bubble, flush_if_id, flush_id_rr              bubble / flush
//   mc_active, mc_reg[3]                                LM/SM sequencing
// -----------------------------------------------------------------------------
interface pipeline_stall_controller_if #(
    parameter int MASK_W = 8
);
    logic              should_stall;
    logic              flush_ex;
    logic              mc_start;
    logic [MASK_W-1:0] mc_mask;

    logic              pc_en;
    logic              if_id_en;
    logic              id_rr_en;
    logic              rr_ex_en;
    logic              rr_ex_bubble;
    logic              flush_if_id;
    logic              flush_id_rr;
    logic              mc_active;
    logic [2:0]        mc_reg;

    modport master (
        output should_stall, flush_ex, mc_start, mc_mask,
        input  pc_en, if_id_en, id_rr_en, rr_ex_en,
        input  rr_ex_bubble, flush_if_id, flush_id_rr,
        input  mc_active, mc_reg
    );

    modport slave (
        input  should_stall, flush_ex, mc_start, mc_mask,
        output pc_en, if_id_en, id_rr_en, rr_ex_en,
        output rr_ex_bubble, flush_if_id, flush_id_rr,
        output mc_active, mc_reg
    );

endinterface : pipeline_stall_controller_if

// File: rtl/pipeline_stall_controller_lowest_set_bit_encoder.sv
// -----------------------------------------------------------------------------
// lowest_set_bit_encoder
// Purely combinational priority encoder: index of the least-significant set
// bit of mask. Used for picking the next LM/SM micro-op register.
// Ports:
//   mask  in  MASK_W  bit vector to encode
//   idx   out IDX_W   index of lowest set bit (0 when mask is zero)
//   valid out 1       mask has at least one bit set
// -----------------------------------------------------------------------------
module lowest_set_bit_encoder
    import pipeline_stall_controller_pkg::*;
#(
    parameter int MASK_W = 8,
    parameter int IDX_W  = REG_IDX_W
) (
    input  logic [MASK_W-1:0] mask,
    output logic [IDX_W-1:0]  idx,
    output logic              valid
);

    // NOTE: combinational blocks use blocking '=' and assign every output a
    // default first, so no path leaves a variable unassigned (no latch).
    always_comb begin
        idx   = '0;
        valid = |mask;
        // Scan from the top down so the lowest set bit is the last write.
        for (int i = MASK_W - 1; i >= 0; i--) begin
            if (mask[i]) begin
                idx = IDX_W'(i);
            end
        end
    end

endmodule : lowest_set_bit_encoder

// File: rtl/pipeline_stall_controller.sv
// -----------------------------------------------------------------------------
// pipeline_stall_controller
// Central stall/flush control for the 6-stage IITB-RISC pipeline. Merges the
// EX redirect (flush_ex), LM/SM multi-cycle issue (mc_start/mc_mask) and the
// hazard unit's load-use request (should_stall), in that priority, into the
// upstream register enables, RR/EX bubble and IF/ID, ID/RR flushes. All
// outputs are combinational from state, current inputs and rst_n.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   bus          pipeline_stall_controller_if.slave (requests in, controls out)
//   stall_cycles[32], flush_count[16]  saturating counters, only when
//                                      STALL_PERF_CNT_EN is defined
// Parameters:
//   LOAD_USE_BUBBLES  bubbles per load-use hazard (1..3)
//   MASK_W            LM/SM register mask width
// Optional build macro: STALL_PERF_CNT_EN
// -----------------------------------------------------------------------------
module pipeline_stall_controller
    import pipeline_stall_controller_pkg::*;
#(
    parameter int LOAD_USE_BUBBLES = 1,
    parameter int MASK_W           = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    pipeline_stall_controller_if.slave   bus
`ifdef STALL_PERF_CNT_EN
    ,
    output logic [31:0]                  stall_cycles,
    output logic [15:0]                  flush_count
`endif
);

    state_t                state, state_nxt;
    logic [BUB_CNT_W-1:0]  bub_cnt, bub_cnt_nxt;
    logic [MASK_W-1:0]     mask_q, mask_nxt;

    logic [MASK_W-1:0]     enc_in;
    logic [MASK_W-1:0]     enc_rest;
    logic [REG_IDX_W-1:0]  lsb_idx;
    logic                  lsb_valid;

    logic                  hold_up;
    logic                  bubble;
    logic                  flush;
    logic                  mc_busy;
    logic [2:0]            mc_idx;
    logic                  pc_en_int;

    // One encoder serves both the first micro-op (fresh mask from RR) and the
    // following ones (stored remainder).
    assign enc_in   = (state == MC_SEQ) ? mask_q : bus.mc_mask;
    // Mask with its lowest set bit removed; zero means this is the last op.
    assign enc_rest = enc_in & (enc_in - MASK_W'(1));

    lowest_set_bit_encoder #(
        .MASK_W (MASK_W),
        .IDX_W  (REG_IDX_W)
    ) u_lsb_enc (
        .mask  (enc_in),
        .idx   (lsb_idx),
        .valid (lsb_valid)
    );

    // NOTE: sequential state uses non-blocking '<=' so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= RUN;
            bub_cnt <= '0;
            mask_q  <= '0;
        end else begin
            state   <= state_nxt;
            bub_cnt <= bub_cnt_nxt;
            mask_q  <= mask_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        bub_cnt_nxt = bub_cnt;
        mask_nxt    = mask_q;
        hold_up     = 1'b0;
        bubble      = 1'b0;
        flush       = 1'b0;
        mc_busy     = 1'b0;
        mc_idx      = 3'd0;

        if (bus.flush_ex) begin
            // Redirect wins over everything and aborts any pending sequence.
            flush       = 1'b1;
            bubble      = 1'b1;
            state_nxt   = RUN;
            bub_cnt_nxt = '0;
            mask_nxt    = '0;
        end else begin
            unique case (state)
                RUN: begin
                    if (bus.mc_start) begin
                        mc_idx   = lsb_valid ? 3'(lsb_idx) : 3'd0;
                        mask_nxt = enc_rest;
                        if (enc_rest != '0) begin
                            hold_up   = 1'b1;
                            mc_busy   = 1'b1;
                            state_nxt = MC_SEQ;
                        end
                    end else if (bus.should_stall) begin
                        hold_up = 1'b1;
                        bubble  = 1'b1;
                        if (LOAD_USE_BUBBLES > 1) begin
                            bub_cnt_nxt = BUB_CNT_W'(LOAD_USE_BUBBLES - 1);
                            state_nxt   = LU_STALL;
                        end
                    end
                end

                LU_STALL: begin
                    // The load is still draining; new requests from RR wait.
                    hold_up = 1'b1;
                    bubble  = 1'b1;
                    if (bub_cnt <= BUB_CNT_W'(1)) begin
                        bub_cnt_nxt = '0;
                        state_nxt   = RUN;
                    end else begin
                        bub_cnt_nxt = bub_cnt - BUB_CNT_W'(1);
                    end
                end

                MC_SEQ: begin
                    mc_idx   = 3'(lsb_idx);
                    mask_nxt = enc_rest;
                    if (enc_rest == '0) begin
                        state_nxt = RUN;
                    end else begin
                        hold_up = 1'b1;
                        mc_busy = 1'b1;
                    end
                end

                default: begin
                    state_nxt   = RUN;
                    bub_cnt_nxt = '0;
                    mask_nxt    = '0;
                end
            endcase
        end
    end

    assign pc_en_int = rst_n & ~hold_up;

    assign bus.pc_en        = pc_en_int;
    assign bus.if_id_en     = rst_n & ~hold_up;
    assign bus.id_rr_en     = rst_n & ~hold_up;
    assign bus.rr_ex_en     = rst_n;
    assign bus.rr_ex_bubble = ~rst_n | bubble;
    assign bus.flush_if_id  = ~rst_n | flush;
    assign bus.flush_id_rr  = ~rst_n | flush;
    assign bus.mc_active    = rst_n & mc_busy;
    assign bus.mc_reg       = rst_n ? mc_idx : 3'd0;

`ifdef STALL_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (!pc_en_int && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
            if (bus.flush_ex && (flush_count != '1)) begin
                flush_count <= flush_count + 16'd1;
            end
        end
    end
`endif

endmodule : pipeline_stall_controller
